// File: rtl/vga_pat_pkg.sv
// ---------------------------------------------------------------------------
// vga_pat_pkg
// Shared definitions for the VGA test-pattern generator:
//   - pat_mode_e   : pattern mode encoding (bars, checker, gradient, box)
//   - RGB565 colour constants and the 10-entry colour-bar palette
//   - grey565()    : expands a 5-bit grey level to an RGB565 word
// ---------------------------------------------------------------------------
package vga_pat_pkg;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRAD    = 2'd2,
        MODE_BOX     = 2'd3
    } pat_mode_e;

    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_ORANGE = 16'hFC00;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_CYAN   = 16'h07FF;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_PURPLE = 16'hF81F;
    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_GRAY   = 16'hD69A;

    localparam logic [15:0] BAR_PALETTE [0:9] = '{
        RGB_RED, RGB_ORANGE, RGB_YELLOW, RGB_GREEN, RGB_CYAN,
        RGB_BLUE, RGB_PURPLE, RGB_BLACK, RGB_WHITE, RGB_GRAY
    };

    // Green is 6 bits wide; the extra LSB replicates the level MSB.
    function automatic logic [15:0] grey565(input logic [4:0] lvl);
        return {lvl, lvl, lvl[4], lvl};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen_if
// Pixel-coordinate / mode-control bundle between the timing source and the
// pattern generator.
//   pix_x, pix_y : current column / row (>= active size means blanking)
//   mode_sel     : requested pattern mode
//   mode_load    : 1-cycle strobe capturing mode_sel
//   pix_data     : RGB565 pixel, 2 cycles after pix_x/pix_y
//   pat_mode     : mode currently displayed
//   frame_end    : registered pulse for the last active pixel of a frame
// master = coordinate/control source, slave = pattern generator.
// ---------------------------------------------------------------------------
interface vga_pattern_gen_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [1:0]  mode_sel;
    logic        mode_load;
    logic [15:0] pix_data;
    logic [1:0]  pat_mode;
    logic        frame_end;

    modport master (
        output pix_x, pix_y, mode_sel, mode_load,
        input  pix_data, pat_mode, frame_end
    );

    modport slave (
        input  pix_x, pix_y, mode_sel, mode_load,
        output pix_data, pat_mode, frame_end
    );
endinterface

// File: rtl/vga_box_mover.sv
// ---------------------------------------------------------------------------
// vga_box_mover
// Position and direction of the bouncing box. Each axis steps one pixel per
// frame end and reverses at its limits with no dwell: at the far limit the
// direction flips and the position decrements on the same frame end (and
// symmetrically at 0).
// Ports:
//   vga_clk     in   pixel clock
//   sys_rst_n   in   asynchronous active-low reset (box to (0,0), dir +x,+y)
//   frame_end_i in   frame-end strobe, one cycle per frame
//   bx_o, by_o  out  top-left corner of the box
// ---------------------------------------------------------------------------
module vga_box_mover #(
    parameter int H_VALID  = 640,
    parameter int V_VALID  = 480,
    parameter int BOX_SIZE = 64
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       frame_end_i,
    output logic [9:0] bx_o,
    output logic [9:0] by_o
);

    localparam logic [9:0] X_LIM = 10'(H_VALID - BOX_SIZE);
    localparam logic [9:0] Y_LIM = 10'(V_VALID - BOX_SIZE);

    logic [9:0] bx_q, bx_d, by_q, by_d;
    logic       dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards larger coordinate

    // Returns {next_dir, next_pos}.
    function automatic logic [10:0] axis_step(input logic fwd, input logic [9:0] pos,
                                              input logic [9:0] lim);
        if (fwd) begin
            if (pos == lim) return {1'b0, pos - 10'd1};
            else            return {1'b1, pos + 10'd1};
        end else begin
            if (pos == 10'd0) return {1'b1, pos + 10'd1};
            else              return {1'b0, pos - 10'd1};
        end
    endfunction

    always_comb begin
        bx_d = bx_q;
        dx_d = dx_q;
        by_d = by_q;
        dy_d = dy_q;
        if (frame_end_i) begin
            {dx_d, bx_d} = axis_step(dx_q, bx_q, X_LIM);
            {dy_d, by_d} = axis_step(dy_q, by_q, Y_LIM);
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bx_q <= '0;
            by_q <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign bx_o = bx_q;
    assign by_o = by_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// Multi-mode VGA test-pattern source (colour bars, checkerboard, grey
// gradient, bouncing box). Two-stage pipeline: S1 registers the active flag,
// a per-mode index and the box-hit flag; S2 maps them to RGB565.
// Mode switches and box motion happen only at frame end, so a frame is never
// rendered with mixed state.
// Ports:
//   vga_clk    in    pixel clock
//   sys_rst_n  in    asynchronous active-low reset
//   pat_if     slave pix_x/pix_y/mode_sel/mode_load in,
//                    pix_data/pat_mode/frame_end out
// Build option:
//   VGA_PAT_AUTO_CYCLE_EN - when defined, a frame counter advances the mode
//   every AUTO_FRAMES frames (mode_load restarts the count).
// ---------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pat_pkg::*;
#(
    parameter int H_VALID     = 640,
    parameter int V_VALID     = 480,
    parameter int NUM_BARS    = 10,
    parameter int CHK_LOG2    = 5,
    parameter int GRAD_MUL    = 51,
`ifdef VGA_PAT_AUTO_CYCLE_EN
    parameter int AUTO_FRAMES = 120,
`endif
    parameter int BOX_SIZE    = 64
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    vga_pattern_gen_if.slave pat_if
);

    localparam logic [9:0]  H_LAST  = 10'(H_VALID - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_VALID - 1);
    localparam int          BAR_W   = H_VALID / NUM_BARS;
    localparam logic [10:0] BOX_EXT = 11'(BOX_SIZE);

    // ---------------- input decode ----------------
    logic active_d;
    logic frame_end_d;

    assign active_d    = (pat_if.pix_x <= H_LAST) && (pat_if.pix_y <= V_LAST);
    assign frame_end_d = (pat_if.pix_x == H_LAST) && (pat_if.pix_y == V_LAST);

    // Bar index: threshold comparators feed a priority pick of the highest
    // threshold passed. The last bar has no upper threshold, so it soaks up
    // the H_VALID % NUM_BARS remainder.
    logic [NUM_BARS-1:0] bar_ge;
    logic [3:0]          bar_idx;

    generate
        for (genvar k = 0; k < NUM_BARS; k++) begin : g_bar_cmp
            assign bar_ge[k] = pat_if.pix_x >= 10'(k * BAR_W);
        end
    endgenerate

    always_comb begin
        bar_idx = '0;
        for (int k = 0; k < NUM_BARS; k++) begin
            if (bar_ge[k]) bar_idx = 4'(k);
        end
    end

    logic       chk_bit;
    logic [9:0] grad_hi;
    logic [4:0] grad_lvl;

    assign chk_bit  = pat_if.pix_x[CHK_LOG2] ^ pat_if.pix_y[CHK_LOG2];
    assign grad_hi  = 10'((20'(pat_if.pix_x) * 20'(GRAD_MUL)) >> 10);
    assign grad_lvl = (grad_hi > 10'd31) ? 5'd31 : grad_hi[4:0];

    // ---------------- box ----------------
    logic [9:0] box_x, box_y;
    logic       box_hit_d;

    vga_box_mover #(
        .H_VALID  (H_VALID),
        .V_VALID  (V_VALID),
        .BOX_SIZE (BOX_SIZE)
    ) u_box_mover (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .frame_end_i (frame_end_d),
        .bx_o        (box_x),
        .by_o        (box_y)
    );

    assign box_hit_d = (pat_if.pix_x >= box_x)
                    && ({1'b0, pat_if.pix_x} < ({1'b0, box_x} + BOX_EXT))
                    && (pat_if.pix_y >= box_y)
                    && ({1'b0, pat_if.pix_y} < ({1'b0, box_y} + BOX_EXT));

    // ---------------- mode control ----------------
    pat_mode_e pat_mode_q, pat_mode_d;
    pat_mode_e pending_q, pending_d;

`ifdef VGA_PAT_AUTO_CYCLE_EN
    localparam logic [6:0] AUTO_LAST = 7'(AUTO_FRAMES - 1);

    logic [6:0] frm_cnt_q, frm_cnt_d;
    logic       auto_wrap;

    always_comb begin
        frm_cnt_d  = frm_cnt_q;
        pending_d  = pending_q;
        pat_mode_d = pat_mode_q;
        // A coincident mode_load takes priority and restarts the count.
        auto_wrap  = frame_end_d && !pat_if.mode_load && (frm_cnt_q == AUTO_LAST);
        if (pat_if.mode_load) begin
            pending_d = pat_mode_e'(pat_if.mode_sel);
            frm_cnt_d = '0;
        end else if (auto_wrap) begin
            pending_d = pat_mode_e'(pat_mode_q + 2'd1);
            frm_cnt_d = '0;
        end else if (frame_end_d) begin
            frm_cnt_d = frm_cnt_q + 7'd1;
        end
        if (auto_wrap) begin
            pat_mode_d = pat_mode_e'(pat_mode_q + 2'd1);
        end else if (frame_end_d) begin
            pat_mode_d = pending_q;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) frm_cnt_q <= '0;
        else            frm_cnt_q <= frm_cnt_d;
    end
`else
    always_comb begin
        pending_d  = pending_q;
        pat_mode_d = pat_mode_q;
        if (pat_if.mode_load) pending_d = pat_mode_e'(pat_if.mode_sel);
        // A load on the frame-end cycle lands in pending only, so the
        // pre-load pending value is what goes on screen now.
        if (frame_end_d) pat_mode_d = pending_q;
    end
`endif

    // ---------------- S1 ----------------
    logic       active_q;
    pat_mode_e  mode_s1_q;
    logic [4:0] idx_q, idx_d;
    logic       box_hit_q;
    logic       frame_end_q;

    always_comb begin
        idx_d = '0;
        case (pat_mode_q)
            MODE_BARS:    idx_d = {1'b0, bar_idx};
            MODE_CHECKER: idx_d = {4'b0, chk_bit};
            MODE_GRAD:    idx_d = grad_lvl;
            MODE_BOX:     idx_d = '0;
            default:      idx_d = '0;
        endcase
    end

    // ---------------- S2 ----------------
    logic [15:0] pix_data_q, pix_data_d;

    always_comb begin
        pix_data_d = RGB_BLACK;
        if (active_q) begin
            case (mode_s1_q)
                MODE_BARS:    pix_data_d = BAR_PALETTE[idx_q[3:0]];
                MODE_CHECKER: pix_data_d = idx_q[0] ? RGB_WHITE : RGB_BLACK;
                MODE_GRAD:    pix_data_d = grey565(idx_q);
                MODE_BOX:     pix_data_d = box_hit_q ? RGB_YELLOW : RGB_BLUE;
                default:      pix_data_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_mode_q  <= MODE_BARS;
            pending_q   <= MODE_BARS;
            active_q    <= 1'b0;
            mode_s1_q   <= MODE_BARS;
            idx_q       <= '0;
            box_hit_q   <= 1'b0;
            frame_end_q <= 1'b0;
            pix_data_q  <= RGB_BLACK;
        end else begin
            pat_mode_q  <= pat_mode_d;
            pending_q   <= pending_d;
            // S1 captures the mode in force for this pixel, so the last
            // pixel of a frame is still drawn in the outgoing mode.
            active_q    <= active_d;
            mode_s1_q   <= pat_mode_q;
            idx_q       <= idx_d;
            box_hit_q   <= box_hit_d;
            frame_end_q <= frame_end_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign pat_if.pix_data  = pix_data_q;
    assign pat_if.pat_mode  = pat_mode_q;
    assign pat_if.frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

    logic vga_clk = 1'b0;
    logic sys_rst_n = 1'b1;

    always #5 vga_clk = ~vga_clk;

    vga_pattern_gen_if bus_a ();
    vga_pattern_gen_if bus_b ();

    vga_pattern_gen dut_a (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .pat_if    (bus_a.slave)
    );

    vga_pattern_gen #(.NUM_BARS(7)) dut_b (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .pat_if    (bus_b.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          sel;
        int          x;
        int          y;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_pix(input int sel, input int x, input int y);
        if (sel == 0) begin
            bus_a.pix_x = 10'(x);
            bus_a.pix_y = 10'(y);
        end else begin
            bus_b.pix_x = 10'(x);
            bus_b.pix_y = 10'(y);
        end
    endtask

    // Present one pixel for one cycle, read its colour two edges later.
    task automatic check_pix(input int sel, input int x, input int y,
                             input logic [15:0] exp, input string name);
        set_pix(sel, x, y);
        @(posedge vga_clk); #1;
        set_pix(sel, 1023, 1023);
        @(posedge vga_clk); #1;
        check(name, (sel == 0) ? bus_a.pix_data : bus_b.pix_data, exp);
    endtask

    // One frame end on instance A, optionally with a coincident mode_load.
    task automatic tick(input logic do_load, input logic [1:0] m);
        bus_a.pix_x = 10'd639;
        bus_a.pix_y = 10'd479;
        if (do_load) begin
            bus_a.mode_sel  = m;
            bus_a.mode_load = 1'b1;
        end
        @(posedge vga_clk); #1;
        bus_a.pix_x     = 10'd1023;
        bus_a.pix_y     = 10'd1023;
        bus_a.mode_load = 1'b0;
    endtask

    task automatic load(input logic [1:0] m);
        bus_a.mode_sel  = m;
        bus_a.mode_load = 1'b1;
        @(posedge vga_clk); #1;
        bus_a.mode_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.pix_x = 10'd1023; bus_a.pix_y = 10'd1023;
        bus_a.mode_sel = 2'd0;  bus_a.mode_load = 1'b0;
        bus_b.pix_x = 10'd1023; bus_b.pix_y = 10'd1023;
        bus_b.mode_sel = 2'd0;  bus_b.mode_load = 1'b0;

        // Colour bars: 10 bars of 64 px (A) and 7 bars of 91 px (B).
        vecs.push_back('{0,   0,   0, 16'hF800, "bar10_x0"});
        vecs.push_back('{0,  63,   0, 16'hF800, "bar10_x63"});
        vecs.push_back('{0,  64,   0, 16'hFC00, "bar10_x64"});
        vecs.push_back('{0, 127,   0, 16'hFC00, "bar10_x127"});
        vecs.push_back('{0, 128,   0, 16'hFFE0, "bar10_x128"});
        vecs.push_back('{0, 200, 479, 16'h07E0, "bar10_x200_y479"});
        vecs.push_back('{0, 320,   0, 16'h001F, "bar10_x320"});
        vecs.push_back('{0, 575,   0, 16'hFFFF, "bar10_x575"});
        vecs.push_back('{0, 576,   0, 16'hD69A, "bar10_x576"});
        vecs.push_back('{0, 639,   0, 16'hD69A, "bar10_x639"});
        vecs.push_back('{0, 640,   0, 16'h0000, "bar10_x640_blank"});
        vecs.push_back('{0,  10, 480, 16'h0000, "bar10_y480_blank"});
        vecs.push_back('{1,   0,   0, 16'hF800, "bar7_x0"});
        vecs.push_back('{1,  90,   0, 16'hF800, "bar7_x90"});
        vecs.push_back('{1,  91,   0, 16'hFC00, "bar7_x91"});
        vecs.push_back('{1, 545,   0, 16'h001F, "bar7_x545"});
        vecs.push_back('{1, 546,   0, 16'hF81F, "bar7_x546"});
        vecs.push_back('{1, 639,   0, 16'hF81F, "bar7_x639"});

        // Reset state
        #2 sys_rst_n = 1'b0;
        #20;
        check("rst_pix_data", bus_a.pix_data, 16'h0000);
        check("rst_pat_mode", bus_a.pat_mode, 16'd0);
        check("rst_frame_end", bus_a.frame_end, 16'd0);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        @(posedge vga_clk); #1;

        foreach (vecs[i]) check_pix(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].name);

        // Mode change applies only at frame end
        load(2'd1);
        check("mode_pending_not_applied", bus_a.pat_mode, 16'd0);
        check_pix(0, 5, 5, 16'hF800, "still_bars_after_load");
        tick(1'b0, 2'd0);
        check("frame_end_pulse", bus_a.frame_end, 16'd1);
        check("mode_applied", bus_a.pat_mode, 16'd1);
        @(posedge vga_clk); #1;
        check("frame_end_one_cycle", bus_a.frame_end, 16'd0);
        check_pix(0,  0,  0, 16'h0000, "chk_0_0");
        check_pix(0, 32,  0, 16'hFFFF, "chk_32_0");
        check_pix(0, 32, 32, 16'h0000, "chk_32_32");
        check_pix(0,  0, 32, 16'hFFFF, "chk_0_32");

        // Last of two loads wins
        load(2'd3);
        load(2'd2);
        tick(1'b0, 2'd0);
        check("last_load_wins", bus_a.pat_mode, 16'd2);

        // Load coincident with frame end waits one more frame
        tick(1'b1, 2'd1);
        check("coincident_load_deferred", bus_a.pat_mode, 16'd2);

        // Gradient: L = min(31, x*51>>10), pixel {L, L, L[4], L}
        check_pix(0,   0,  0, 16'h0000, "grad_x0");
        check_pix(0, 100,  5, 16'h2104, "grad_x100");
        check_pix(0, 320, 10, 16'h7BCF, "grad_x320");
        check_pix(0, 639,  0, 16'hFFFF, "grad_x639");
        check_pix(0, 640,  0, 16'h0000, "grad_blank");
        check_pix(0, 639, 479, 16'hFFFF, "grad_last_pixel_old_mode");
        check("coincident_load_applied", bus_a.pat_mode, 16'd1);

        // Reset mid-frame while showing the box
        tick(1'b1, 2'd3);
        tick(1'b0, 2'd0);
        check("box_mode_before_reset", bus_a.pat_mode, 16'd3);
        set_pix(0, 100, 50);
        @(posedge vga_clk); #2;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_pat_mode", bus_a.pat_mode, 16'd0);
        check("midrst_pix_data", bus_a.pix_data, 16'h0000);
        check("midrst_frame_end", bus_a.frame_end, 16'd0);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        set_pix(0, 0, 0);
        @(posedge vga_clk); #1;
        check("refill_black", bus_a.pix_data, 16'h0000);
        @(posedge vga_clk); #1;
        set_pix(0, 1023, 1023);
        check("refill_bar0", bus_a.pix_data, 16'hF800);

        // Bouncing box from a fresh reset: frame n puts the box at
        // x = n (bounce after 576), y = n (bounce after 416).
        tick(1'b1, 2'd3);   // load only; box (1,1), mode still 0
        tick(1'b1, 2'd3);   // box (2,2), mode 3
        check("box_mode", bus_a.pat_mode, 16'd3);
        check_pix(0,  2,  2, 16'hFFE0, "box2_corner");
        check_pix(0,  1,  2, 16'h001F, "box2_left");
        check_pix(0,  2,  1, 16'h001F, "box2_above");
        check_pix(0, 65, 65, 16'hFFE0, "box2_far_corner");
        check_pix(0, 66,  2, 16'h001F, "box2_right");
        check_pix(0,  2, 66, 16'h001F, "box2_below");
        for (int i = 2; i < 416; i++) tick(1'b1, 2'd3);
        check_pix(0, 416, 416, 16'hFFE0, "box416_corner");
        check_pix(0, 416, 415, 16'h001F, "box416_above");
        check_pix(0, 479, 479, 16'hFFE0, "box416_bottom_edge");
        check_pix(0, 415, 416, 16'h001F, "box416_left");
        tick(1'b1, 2'd3);
        check_pix(0, 417, 415, 16'hFFE0, "box417_y_bounced");
        check_pix(0, 417, 414, 16'h001F, "box417_above");
        check_pix(0, 417, 479, 16'h001F, "box417_below");
        for (int i = 417; i < 576; i++) tick(1'b1, 2'd3);
        check_pix(0, 576, 256, 16'hFFE0, "box576_corner");
        check_pix(0, 575, 256, 16'h001F, "box576_left");
        check_pix(0, 639, 319, 16'hFFE0, "box576_right_edge");
        check_pix(0, 639, 320, 16'h001F, "box576_below");
        tick(1'b1, 2'd3);
        check_pix(0, 575, 255, 16'hFFE0, "box577_x_bounced");
        check_pix(0, 639, 255, 16'h001F, "box577_right");
        check_pix(0, 638, 318, 16'hFFE0, "box577_far_corner");
        check_pix(0, 575, 254, 16'h001F, "box577_above");

`ifdef VGA_PAT_AUTO_CYCLE_EN
        @(negedge vga_clk);
        sys_rst_n = 1'b0;
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 119; i++) tick(1'b0, 2'd0);
        check("auto_119", bus_a.pat_mode, 16'd0);
        tick(1'b0, 2'd0);
        check("auto_120", bus_a.pat_mode, 16'd1);
        for (int i = 0; i < 360; i++) tick(1'b0, 2'd0);
        check("auto_480_wrap", bus_a.pat_mode, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
